// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the two-requester scratch-SRAM arbiter.
package sram_arb_pkg;
  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 128;
  localparam int KEY_LIMIT_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;
endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle: port A (AHB slave) and port B (AES engine).
interface sram_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              a_req, a_we, a_gnt, a_done, a_err;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic              b_req, b_we, b_gnt, b_done;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_done, a_err, a_rdata, b_gnt, b_done, b_rdata
  );
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_done, a_err, a_rdata, b_gnt, b_done, b_rdata
  );
endinterface

// File: rtl/sram_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick; winner 0 = A, 1 = B.
module rr_arbiter2 (
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic valid,
  output logic winner
);
  assign valid  = a_req | b_req;
  // On a tie the requester not served last wins.
  assign winner = (a_req && b_req) ? ~last_grant : b_req;
endmodule

// File: rtl/sram_arbiter.sv
// Scratch-SRAM arbiter: IDLE -> SETUP -> ACCESS (strobe) -> DONE, round-robin between A and B.
// Optional macro SRAM_ARB_KEY_PROTECT_EN blocks A reads below KEY_LIMIT and flags them with a_err.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int KEY_LIMIT = KEY_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  sram_arbiter_if.slave     rq,
  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              last_grant
);
`ifdef SRAM_ARB_KEY_PROTECT_EN
  localparam bit KEY_PROT_EN = 1'b1;
`else
  localparam bit KEY_PROT_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  req_id_e           owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d, prot_q, prot_d;
  logic              busy_q, busy_d;
  logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic              a_done_q, a_done_d, b_done_q, b_done_d, a_err_q, a_err_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic              pick_vld, pick_b, sel_we, key_hit;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_rr (
    .a_req      (rq.a_req),
    .b_req      (rq.b_req),
    .last_grant (last_q),
    .valid      (pick_vld),
    .winner     (pick_b)
  );

  assign sel_we    = pick_b ? rq.b_we    : rq.a_we;
  assign sel_addr  = pick_b ? rq.b_addr  : rq.a_addr;
  assign sel_wdata = pick_b ? rq.b_wdata : rq.a_wdata;
  assign key_hit   = KEY_PROT_EN && !pick_b && !rq.a_we &&
                     (rq.a_addr < ADDR_W'(KEY_LIMIT));

  // Only the latched owner/we/prot are kept; the SRAM pins double as the
  // latched address and write data while a transaction is in flight.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    prot_d    = prot_q;
    busy_d    = busy_q;
    a_gnt_d   = a_gnt_q;
    b_gnt_d   = b_gnt_q;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;
    a_err_d   = 1'b0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_SETUP;
          owner_d = req_id_e'(pick_b);
          we_d    = sel_we;
          prot_d  = key_hit;
          busy_d  = 1'b1;
          a_gnt_d = !pick_b;
          b_gnt_d = pick_b;
          addr_d  = key_hit ? '0 : sel_addr;
          wdata_d = sel_we ? sel_wdata : '0;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        rd_d    = !we_q && !prot_q;
        wr_d    = we_q;
      end
      ST_ACCESS: begin
        state_d  = ST_DONE;
        addr_d   = '0;
        wdata_d  = '0;
        a_done_d = (owner_q == REQ_A);
        b_done_d = (owner_q == REQ_B);
        a_err_d  = prot_q;
        if (!we_q) begin
          if (owner_q == REQ_A) a_rdata_d = prot_q ? '0 : sram_rdata;
          else                  b_rdata_d = sram_rdata;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        a_gnt_d = 1'b0;
        b_gnt_d = 1'b0;
        last_d  = owner_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= REQ_A;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      prot_q    <= 1'b0;
      busy_q    <= 1'b0;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_err_q   <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      prot_q    <= prot_d;
      busy_q    <= busy_d;
      a_gnt_q   <= a_gnt_d;
      b_gnt_q   <= b_gnt_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_err_q   <= a_err_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign rq.a_gnt   = a_gnt_q;
  assign rq.b_gnt   = b_gnt_q;
  assign rq.a_done  = a_done_q;
  assign rq.b_done  = b_done_q;
  assign rq.a_err   = a_err_q;
  assign rq.a_rdata = a_rdata_q;
  assign rq.b_rdata = b_rdata_q;
  assign sram_read  = rd_q;
  assign sram_write = wr_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign busy       = busy_q;
  assign last_grant = last_q;
endmodule
